// File: rtl/mixer_integrator.sv
// Integrate-and-dump low-pass stage after the square-wave mixer: sums whole
// oscillator periods aligned to phase-counter wrap and emits one scaled, saturated sample per window.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | disabled; accumulator and period count held at zero
// ALIGN     | enabled, waiting for counterIn==0 to open the first window
// INTEGRATE | summing samples; dumps on the last boundary of the window
module mixer_integrator #(
  parameter int inBitDepth      = 15,
  parameter int counterBitDepth = 5,
  parameter int accBitDepth     = 32,
  parameter int outBitDepth     = 16,
  parameter int decimBitDepth   = 16
) (
  input  logic                              clk64,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              clearIn,
  input  logic signed [inBitDepth-1:0]      inWire,
  input  logic        [counterBitDepth-1:0] counterIn,
  input  logic        [decimBitDepth-1:0]   decimPeriods,
  input  logic        [4:0]                 shiftIn,
  output logic signed [outBitDepth-1:0]     outWire,
  output logic                              outValid,
  output logic                              overflow
);

  typedef enum logic [1:0] {IDLE, ALIGN, INTEGRATE} state_t;

  localparam logic signed [accBitDepth-1:0] ACC_MAX = {1'b0, {(accBitDepth-1){1'b1}}};
  localparam logic signed [accBitDepth-1:0] ACC_MIN = {1'b1, {(accBitDepth-1){1'b0}}};
  localparam logic signed [accBitDepth-1:0] OUT_MAX =
    {{(accBitDepth-outBitDepth+1){1'b0}}, {(outBitDepth-1){1'b1}}};
  localparam logic signed [accBitDepth-1:0] OUT_MIN =
    {{(accBitDepth-outBitDepth+1){1'b1}}, {(outBitDepth-1){1'b0}}};
  localparam logic [decimBitDepth-1:0] DECIM_ONE = decimBitDepth'(1);

  state_t                          state_q, state_d;
  logic signed [accBitDepth-1:0]   acc_q, acc_d;
  logic        [decimBitDepth-1:0] period_q, period_d;
  logic        [decimBitDepth-1:0] decim_q, decim_d;
  logic signed [accBitDepth-1:0]   dump_q, dump_d;
  logic                            dump_v_q, dump_v_d;
  logic signed [accBitDepth-1:0]   shifted_q, shifted_d;
  logic                            shift_v_q, shift_v_d;
  logic signed [outBitDepth-1:0]   out_q, out_d;
  logic                            valid_q, valid_d;
  logic                            ovf_q, ovf_d;

  logic                            boundary;
  logic signed [accBitDepth-1:0]   in_ext;
  logic signed [accBitDepth:0]     sum_wide;
  logic signed [accBitDepth-1:0]   acc_sum;
  logic                            acc_clip;
  logic        [decimBitDepth-1:0] decim_eff;
  logic                            last_period;
  logic                            out_hi, out_lo;

  always_comb begin
    boundary    = (counterIn == '0);
    in_ext      = {{(accBitDepth-inBitDepth){inWire[inBitDepth-1]}}, inWire};
    sum_wide    = {acc_q[accBitDepth-1], acc_q} + {in_ext[accBitDepth-1], in_ext};
    acc_clip    = (sum_wide[accBitDepth] != sum_wide[accBitDepth-1]);
    acc_sum     = sum_wide[accBitDepth-1:0];
    if (acc_clip) acc_sum = sum_wide[accBitDepth] ? ACC_MIN : ACC_MAX;
    decim_eff   = (decimPeriods == '0) ? DECIM_ONE : decimPeriods;
    last_period = (period_q == (decim_q - DECIM_ONE));
    out_hi      = (shifted_q > OUT_MAX);
    out_lo      = (shifted_q < OUT_MIN);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    period_d  = period_q;
    decim_d   = decim_q;
    dump_d    = dump_q;
    dump_v_d  = 1'b0;
    shifted_d = shifted_q;
    shift_v_d = dump_v_q;
    out_d     = out_q;
    valid_d   = shift_v_q;
    ovf_d     = ovf_q;

    // Dump pipeline runs independently of enable so an in-flight result still lands.
    if (dump_v_q) shifted_d = dump_q >>> shiftIn;
    if (shift_v_q) begin
      if (out_hi)      out_d = OUT_MAX[outBitDepth-1:0];
      else if (out_lo) out_d = OUT_MIN[outBitDepth-1:0];
      else             out_d = shifted_q[outBitDepth-1:0];
      if (out_hi || out_lo) ovf_d = 1'b1;
    end

    if (clearIn) begin
      state_d   = enable ? ALIGN : IDLE;
      acc_d     = '0;
      period_d  = '0;
      ovf_d     = 1'b0;
      shift_v_d = 1'b0;
      valid_d   = 1'b0;
      out_d     = out_q;
    end else if (!enable) begin
      state_d  = IDLE;
      acc_d    = '0;
      period_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ALIGN;
        end
        ALIGN: begin
          if (boundary) begin
            state_d  = INTEGRATE;
            acc_d    = in_ext;
            period_d = '0;
            decim_d  = decim_eff;
          end
        end
        INTEGRATE: begin
          if (boundary && last_period) begin
            // Window closes: the current sample opens the next window.
            dump_d   = acc_q;
            dump_v_d = 1'b1;
            acc_d    = in_ext;
            period_d = '0;
            decim_d  = decim_eff;
          end else begin
            acc_d = acc_sum;
            if (acc_clip) ovf_d = 1'b1;
            if (boundary) period_d = period_q + DECIM_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk64 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      period_q  <= '0;
      decim_q   <= '0;
      dump_q    <= '0;
      dump_v_q  <= 1'b0;
      shifted_q <= '0;
      shift_v_q <= 1'b0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      period_q  <= period_d;
      decim_q   <= decim_d;
      dump_q    <= dump_d;
      dump_v_q  <= dump_v_d;
      shifted_q <= shifted_d;
      shift_v_q <= shift_v_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign outWire  = out_q;
  assign outValid = valid_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mixer_integrator.sv
// Bench for mixer_integrator: directed scenarios plus random stimulus, checked
// every cycle against a window-level reference model (sums, boundary counts, result queue).
module tb_mixer_integrator;

  logic               clk64 = 1'b0;
  logic               rst_n = 1'b1;
  logic               en = 1'b0;
  logic               clr = 1'b0;
  logic signed [14:0] x = '0;
  logic        [4:0]  cnt = '0;
  logic        [15:0] decim = 16'd1;
  logic        [4:0]  shft = '0;
  logic signed [15:0] outWire;
  logic               outValid;
  logic               overflow;

  int n_run = 0;
  int n_fail = 0;

  // Reference model: window results wait in a queue until their due cycle.
  longint             q_val[$];
  longint             q_due[$];
  longint             m_cycle = 0;
  longint             m_sum = 0;
  int                 m_bnd = 0;
  int                 m_target = 1;
  bit                 m_armed = 0;
  bit                 m_inwin = 0;
  logic signed [15:0] m_out = '0;
  logic               m_valid = 1'b0;
  logic               m_ovf = 1'b0;

  mixer_integrator dut (
    .clk64(clk64), .rst_n(rst_n), .enable(en), .clearIn(clr),
    .inWire(x), .counterIn(cnt), .decimPeriods(decim), .shiftIn(shft),
    .outWire(outWire), .outValid(outValid), .overflow(overflow)
  );

  always #8 clk64 = ~clk64;

  task automatic model_reset();
    q_val.delete(); q_due.delete();
    m_sum = 0; m_bnd = 0; m_armed = 0; m_inwin = 0;
    m_out = '0; m_valid = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    longint s;
    m_cycle++;
    if (!rst_n) begin model_reset(); return; end
    m_valid = 1'b0;
    if (clr) begin
      q_val.delete(); q_due.delete();
      m_ovf = 1'b0; m_sum = 0; m_bnd = 0; m_inwin = 0; m_armed = en;
      return;
    end
    if (q_due.size() > 0 && q_due[0] == m_cycle) begin
      void'(q_due.pop_front());
      s = q_val.pop_front() >>> shft;
      if (s > 32767)       begin s = 32767;  m_ovf = 1'b1; end
      else if (s < -32768) begin s = -32768; m_ovf = 1'b1; end
      m_out = 16'(s);
      m_valid = 1'b1;
    end
    if (!en) begin
      m_armed = 0; m_inwin = 0; m_sum = 0;
    end else if (!m_armed) begin
      m_armed = 1;
    end else if (!m_inwin) begin
      if (cnt == 0) begin
        m_inwin = 1; m_sum = longint'(x); m_bnd = 0;
        m_target = (decim == 0) ? 1 : int'(decim);
      end
    end else if (cnt == 0 && m_bnd + 1 == m_target) begin
      q_val.push_back(m_sum); q_due.push_back(m_cycle + 2);
      m_sum = longint'(x); m_bnd = 0;
      m_target = (decim == 0) ? 1 : int'(decim);
    end else begin
      if (cnt == 0) m_bnd++;
      m_sum = m_sum + longint'(x);
      if (m_sum > 64'sd2147483647)       begin m_sum = 64'sd2147483647;  m_ovf = 1'b1; end
      else if (m_sum < -64'sd2147483648) begin m_sum = -64'sd2147483648; m_ovf = 1'b1; end
    end
  endtask

  task automatic tick();
    @(posedge clk64);
    model_step();
    #1;
    cnt = cnt + 5'd1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #2;
    n_run++;
    if (outWire !== 16'sd0 || outValid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state out=%0d valid=%b ovf=%b required 0/0/0", outWire, outValid, overflow);
    end
    repeat (3) begin
      tick();
      n_run++;
      if (outValid !== m_valid || outWire !== m_out || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d valid=%b/%b out=%0d/%0d ovf=%b/%b", m_cycle,
                 outValid, m_valid, outWire, m_out, overflow, m_ovf);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_constant();
    longint last = -1;
    int strobes = 0;
    x = 15'sd100; decim = 16'd1; shft = 5'd0; en = 1'b1; cnt = 5'd9;
    for (int i = 0; i < 200; i++) begin
      tick();
      n_run++;
      if (outValid !== m_valid || outWire !== m_out || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL constant cyc=%0d valid=%b/%b out=%0d/%0d ovf=%b/%b", m_cycle,
                 outValid, m_valid, outWire, m_out, overflow, m_ovf);
      end
      if (outValid === 1'b1) begin
        strobes++;
        n_run++;
        if (outWire !== 16'sd3200 || cnt !== 5'd3 || (last >= 0 && m_cycle - last != 32)) begin
          n_fail++;
          $display("FAIL constant_value out=%0d phase=%0d gap=%0d required 3200/3/32",
                   outWire, cnt, m_cycle - last);
        end
        last = m_cycle;
      end
    end
    n_run++;
    if (strobes < 5 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL constant_count strobes=%0d ovf=%b required >=5/0", strobes, overflow);
    end
  endtask

  task automatic test_decim_change();
    longint t[$];
    logic signed [15:0] v[$];
    int n;
    x = -15'sd100; decim = 16'd4; shft = 5'd5; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (i == 300) decim = 16'd2;
      tick();
      n_run++;
      if (outValid !== m_valid || outWire !== m_out || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL decim_change cyc=%0d valid=%b/%b out=%0d/%0d ovf=%b/%b", m_cycle,
                 outValid, m_valid, outWire, m_out, overflow, m_ovf);
      end
      if (outValid === 1'b1) begin t.push_back(m_cycle); v.push_back(outWire); end
    end
    n = t.size();
    n_run++;
    if (n < 6 || v[0] !== -16'sd400 || v[n-1] !== -16'sd200 ||
        t[1] - t[0] != 128 || t[n-1] - t[n-2] != 64) begin
      n_fail++;
      $display("FAIL decim_change_windows strobes=%0d first=%0d last=%0d required >=6/-400/-200",
               n, (n > 0) ? v[0] : 16'sd0, (n > 0) ? v[n-1] : 16'sd0);
    end
  endtask

  task automatic test_zero_decim_alternating();
    int strobes = 0;
    decim = 16'd0; shft = 5'd0; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 200; i++) begin
      x = cnt[0] ? -15'sd50 : 15'sd50;
      tick();
      n_run++;
      if (outValid !== m_valid || outWire !== m_out || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL alternating cyc=%0d valid=%b/%b out=%0d/%0d ovf=%b/%b", m_cycle,
                 outValid, m_valid, outWire, m_out, overflow, m_ovf);
      end
      if (outValid === 1'b1) begin
        strobes++;
        n_run++;
        if (outWire !== 16'sd0) begin
          n_fail++;
          $display("FAIL alternating_value out=%0d required 0", outWire);
        end
      end
    end
    n_run++;
    if (strobes < 5) begin
      n_fail++;
      $display("FAIL zero_decim_windows strobes=%0d required >=5", strobes);
    end
  endtask

  task automatic test_saturation_clear();
    int strobes = 0;
    longint t_clr;
    bit seen = 0;
    x = 15'sd16383; decim = 16'd100; shft = 5'd0; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 7000 && strobes < 2; i++) begin
      tick();
      n_run++;
      if (outValid !== m_valid || outWire !== m_out || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL saturation cyc=%0d valid=%b/%b out=%0d/%0d ovf=%b/%b", m_cycle,
                 outValid, m_valid, outWire, m_out, overflow, m_ovf);
      end
      if (outValid === 1'b1) begin
        strobes++;
        n_run++;
        if (outWire !== 16'sd32767 || overflow !== 1'b1) begin
          n_fail++;
          $display("FAIL saturation_value out=%0d ovf=%b required 32767/1", outWire, overflow);
        end
      end
    end
    n_run++;
    if (strobes < 2 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL saturation_sticky strobes=%0d ovf=%b required 2/1", strobes, overflow);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    t_clr = m_cycle;
    n_run++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_overflow ovf=%b required 0", overflow);
    end
    for (int i = 0; i < 7000 && !seen; i++) begin
      tick();
      n_run++;
      if (outValid !== m_valid || outWire !== m_out || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL post_clear cyc=%0d valid=%b/%b out=%0d/%0d ovf=%b/%b", m_cycle,
                 outValid, m_valid, outWire, m_out, overflow, m_ovf);
      end
      if (outValid === 1'b1) seen = 1;
    end
    n_run++;
    if (!seen || m_cycle - t_clr < 3200 + 2) begin
      n_fail++;
      $display("FAIL clear_realign seen=%0d gap=%0d required 1/>=3202", seen, m_cycle - t_clr);
    end
  endtask

  task automatic test_enable_drop();
    bit seen = 0;
    longint t_en;
    x = 15'sd100; decim = 16'd1; shft = 5'd0; en = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (outValid === 1'b1) seen = 1;
    end
    for (int i = 0; i < 40 && cnt != 5'd17; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_run++;
      if (outValid !== 1'b0 || outWire !== 16'sd3200 || outValid !== m_valid || outWire !== m_out) begin
        n_fail++;
        $display("FAIL enable_low cyc=%0d valid=%b out=%0d required 0/3200", m_cycle, outValid, outWire);
      end
    end
    en = 1'b1;
    t_en = m_cycle;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      n_run++;
      if (outValid !== m_valid || outWire !== m_out || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL enable_resume cyc=%0d valid=%b/%b out=%0d/%0d ovf=%b/%b", m_cycle,
                 outValid, m_valid, outWire, m_out, overflow, m_ovf);
      end
      if (outValid === 1'b1) seen = 1;
    end
    n_run++;
    if (!seen || outWire !== 16'sd3200 || m_cycle - t_en < 34) begin
      n_fail++;
      $display("FAIL enable_full_window seen=%0d out=%0d gap=%0d required 1/3200/>=34",
               seen, outWire, m_cycle - t_en);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    for (int k = 0; k < 2; k++) begin
      seen = 0;
      for (int i = 0; i < 150 && !seen; i++) begin
        tick();
        if (outValid === 1'b1) seen = 1;
      end
      if (k == 0) repeat (10) tick();
      else for (int i = 0; i < 40 && cnt != 5'd1; i++) tick();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_run++;
      if (outWire !== 16'sd0 || outValid !== 1'b0 || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset k=%0d out=%0d valid=%b ovf=%b required 0/0/0", k, outWire, outValid, overflow);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 34; i++) begin
        tick();
        n_run++;
        if (outValid !== 1'b0 || outWire !== 16'sd0 || outValid !== m_valid || overflow !== m_ovf) begin
          n_fail++;
          $display("FAIL reset_release k=%0d cyc=%0d valid=%b out=%0d required 0/0", k, m_cycle, outValid, outWire);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      x = 15'($urandom_range(0, 32767));
      clr = ($urandom_range(0, 199) == 0);
      if (clr) begin
        decim = 16'($urandom_range(0, 3));
        shft = 5'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 299) == 0) en = ~en;
      if ($urandom_range(0, 499) == 0) cnt = 5'($urandom_range(0, 31));
      tick();
      n_run++;
      if (outValid !== m_valid || outWire !== m_out || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL random cyc=%0d valid=%b/%b out=%0d/%0d ovf=%b/%b", m_cycle,
                 outValid, m_valid, outWire, m_out, overflow, m_ovf);
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_constant();
    test_decim_change();
    test_zero_decim_alternating();
    test_saturation_clear();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mixer_integrator.md
Name: mixer_integrator

Overview:
- Integrate-and-dump low-pass stage directly downstream of the square-wave mixer; consumes the mixer's signed output and the shared modulation-oscillator phase counter.
- Sums mixer output over an integer number of oscillator periods, aligned to counter wrap, so the demodulated error signal has no ripple at the modulation frequency.
- Emits one scaled, saturated sample per window with a single-cycle valid strobe to the PID stage.

Parameters:
- inBitDepth, 15, width of signed mixer output (14-bit ADC path plus 1).
- counterBitDepth, 5, width of oscillator phase counter; one period = 2^counterBitDepth cycles.
- accBitDepth, 32, signed accumulator width.
- outBitDepth, 16, signed output width.
- decimBitDepth, 16, width of the periods-per-window setting.

Ports:
- clk64  input  1  system clock, 64 MHz.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  run integrator; low forces IDLE.
- clearIn  input  1  synchronous clear of accumulator, window and sticky flag; restarts alignment.
- inWire  input  inBitDepth  signed mixer output, one sample per cycle.
- counterIn  input  counterBitDepth  oscillator phase counter, free-running and wrapping.
- decimPeriods  input  decimBitDepth  oscillator periods per window; 0 is treated as 1.
- shiftIn  input  5  arithmetic right shift applied to window sum before output saturation.
- outWire  output  outBitDepth  signed window result.
- outValid  output  1  one-cycle strobe when outWire updates.
- overflow  output  1  sticky; set on accumulator or output saturation.

Behaviour:
- Reset (async, rst_n low): state IDLE, acc=0, periodCount=0, outWire=0, outValid=0, overflow=0, dump pipeline cleared.
- Boundary: any cycle with counterIn==0.
- States:
  - IDLE: entered on reset or enable low; acc and periodCount zeroed; outWire holds its last value; no strobe. Goes to ALIGN when enable is high.
  - ALIGN: waits for a boundary. On a boundary: acc<=inWire, periodCount<=0, decimLatched<=max(decimPeriods,1), then go to INTEGRATE.
  - INTEGRATE, non-boundary cycle: acc<=sat(acc+inWire).
  - INTEGRATE, boundary with periodCount!=decimLatched-1: periodCount++ and acc<=sat(acc+inWire).
  - INTEGRATE, boundary with periodCount==decimLatched-1 (dump): dumpReg<=acc (sum excludes the current sample); acc<=inWire; periodCount<=0; decimLatched reloads from decimPeriods.
- No sample is lost or counted twice across consecutive windows. Each window sums exactly decimLatched*2^counterBitDepth samples.
- decimPeriods changes take effect only at the next window start.
- Dump pipeline: at dump edge+1, shifted = dumpReg >>> shiftIn (sign-preserving). At dump edge+2, outWire <= shifted saturated to outBitDepth, and outValid=1 for exactly one cycle. Latency from dump edge to outValid: 2 cycles.
- Accumulator saturation: clamps at +/-(2^(accBitDepth-1)) limits (max positive / min negative); sets overflow.
- Output saturation: clamps to [-2^(outBitDepth-1), 2^(outBitDepth-1)-1]; sets overflow.
- overflow clears only on reset or clearIn.
- clearIn: highest synchronous priority. acc=0, periodCount=0, overflow=0, state ALIGN (IDLE if enable low). Any in-flight dump is discarded: no outValid and outWire unchanged. When clearIn coincides with a boundary, alignment starts at the next boundary, not the current one.
- enable falling mid-window: partial sum discarded, no strobe, IDLE next cycle. An in-flight dump pipeline still completes.
- Counter discontinuity: if counterIn jumps (e.g. oscillator reset), windows still realign only on counterIn==0; no error flagged.
- Widths: inWire sign-extended to accBitDepth before add; no other truncation besides shift and saturation.

Test Plan:
- Constant input: counterBitDepth=5, counterIn free-running 0..31, inWire=100, decimPeriods=1, shiftIn=0 -> first outValid 2 cycles after the second boundary, outWire=3200, repeating every 32 cycles; overflow=0.
- Shift and decimation: inWire=-100, decimPeriods=4, shiftIn=5 -> outWire=-400 every 128 cycles. Change decimPeriods to 2 mid-window -> current window still 128 cycles, then windows of 64 cycles with outWire=-200.
- decimPeriods=0 -> behaves as 1. inWire alternating +50/-50 per cycle -> outWire=0 each window.
- Output saturation: inWire=16383, decimPeriods=100, shiftIn=0 -> outWire=32767, overflow=1 and stays 1. clearIn pulse -> overflow=0; first outValid arrives only after one full realigned window.
- Enable low at counterIn=17 mid-window -> no strobe, outWire holds; enable high -> ALIGN waits for counterIn==0, next outWire is a full-window value.
- rst_n low mid-window and during the dump pipeline -> all outputs 0 immediately (async), no strobe after release until a full aligned window completes.
